// File: rtl/smart_systolic_skew_feeder.sv
// smart_systolic_skew_feeder
//
// Buffers row-vectors of activations (one word per array row) in a small
// FIFO. On start, it streams one buffered vector per cycle onto left_out_bus.
// The bus is diagonally skewed, so lane i lags lane 0 by i cycles. After the
// frame's last vector, the skew pipeline is drained with zeros and done pulses
// when the final lane word is on the bus.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   in_data         row-vector; lane i = bits [i*WORD_SIZE +: WORD_SIZE]
//   in_last         marks the final vector of a frame (stored with the vector)
//   in_valid        producer offers in_data/in_last
//   in_ready        FIFO can accept (transfer on in_valid & in_ready)
//   start           one-cycle pulse, honoured only while idle
//   left_out_bus    skewed data towards the array's left_in_bus
//   lane_valid      bit i set when lane i carries a real popped word
//   busy            streaming or flushing
//   done            one-cycle pulse with the frame's final lane word
//   underflow_err   sticky: a pop was due while the FIFO was empty
module smart_systolic_skew_feeder #(
    parameter int WORD_SIZE   = 16,
    parameter int CELL_HEIGHT = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CELL_HEIGHT*WORD_SIZE-1:0] in_data,
    input  logic                             in_last,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             start,
    output logic [CELL_HEIGHT*WORD_SIZE-1:0] left_out_bus,
    output logic [CELL_HEIGHT-1:0]           lane_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             underflow_err
);
    localparam int VEC_W   = CELL_HEIGHT * WORD_SIZE;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FLUSH_W = $clog2(CELL_HEIGHT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [FLUSH_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic                 done_reg, done_next;
    logic                 underflow_reg, underflow_next;

    // ------------------------------------------------------------------
    // FIFO. The data words live in a RAM-style array. The last flags are
    // kept in flops because the FSM needs the head flag in the pop cycle.
    // ------------------------------------------------------------------
    logic [VEC_W-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_bits_reg;
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  full, empty, push, pop;

    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    // The pop only looks at entries present at the start of the cycle.
    // This means an incoming word is never bypassed straight to the output.
    assign pop      = (state_reg == STREAM) && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg]           <= in_data;
            last_bits_reg[wr_ptr_reg] <= in_last;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pop register: stage 0 of every lane, and the registered RAM read.
    // Whenever no entry is popped, a zero word with a cleared valid is
    // injected.
    // ------------------------------------------------------------------
    logic [VEC_W-1:0] pop_data_reg;
    logic             pop_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data_reg  <= '0;
            pop_valid_reg <= 1'b0;
        end else if (pop) begin
            pop_data_reg  <= mem[rd_ptr_reg];
            pop_valid_reg <= 1'b1;
        end else begin
            pop_data_reg  <= '0;
            pop_valid_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Skew pipeline. Lane gi adds gi delay stages after the pop register.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CELL_HEIGHT; gi++) begin : g_lane
            if (gi == 0) begin : g_direct
                assign left_out_bus[0 +: WORD_SIZE] = pop_data_reg[0 +: WORD_SIZE];
                assign lane_valid[0]                = pop_valid_reg;
            end else begin : g_delay
                logic [WORD_SIZE-1:0] data_reg [1:gi];
                logic [gi:1]          valid_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int s = 1; s <= gi; s++) begin
                            data_reg[s] <= '0;
                        end
                        valid_reg <= '0;
                    end else begin
                        data_reg[1]  <= pop_data_reg[gi*WORD_SIZE +: WORD_SIZE];
                        valid_reg[1] <= pop_valid_reg;
                        for (int s = 2; s <= gi; s++) begin
                            data_reg[s]  <= data_reg[s-1];
                            valid_reg[s] <= valid_reg[s-1];
                        end
                    end
                end

                assign left_out_bus[gi*WORD_SIZE +: WORD_SIZE] = data_reg[gi];
                assign lane_valid[gi]                          = valid_reg[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            flush_cnt_reg <= '0;
            done_reg      <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            done_reg      <= done_next;
            underflow_reg <= underflow_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        done_next      = 1'b0;
        underflow_next = underflow_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = STREAM;
                    underflow_next = 1'b0;
                end
            end
            STREAM: begin
                if (empty) begin
                    // A bubble is injected by the pop register; stay and wait.
                    underflow_next = 1'b1;
                end else if (last_bits_reg[rd_ptr_reg]) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_W'(CELL_HEIGHT - 1);
                end
            end
            FLUSH: begin
                flush_cnt_next = flush_cnt_reg - FLUSH_W'(1);
                // done is registered, so it lands together with the last
                // lane's word.
                if (flush_cnt_reg == FLUSH_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy          = (state_reg != IDLE);
    assign done          = done_reg;
    assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_smart_systolic_skew_feeder.sv
// Testbench for smart_systolic_skew_feeder.
// The stimulus side drives the inputs and also runs a behavioural model of
// the feeder. The model is built from queues: a FIFO of vectors, plus an
// abstract streaming/flush timeline. It pushes the expected lane words
// (stamped with their due cycle), the expected done cycles, and the
// expected per-cycle in_ready/busy/underflow_err. A separate monitor
// compares these against the DUT on every falling edge.
module tb_smart_systolic_skew_feeder;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int D  = 8;
    localparam int DW = W * CH;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic          start;
    logic [DW-1:0] left_out_bus;
    logic [CH-1:0] lane_valid;
    logic          busy;
    logic          done;
    logic          underflow_err;

    always #5 clk = ~clk;

    smart_systolic_skew_feeder #(
        .WORD_SIZE  (W),
        .CELL_HEIGHT(CH),
        .FIFO_DEPTH (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .left_out_bus (left_out_bus),
        .lane_valid   (lane_valid),
        .busy         (busy),
        .done         (done),
        .underflow_err(underflow_err)
    );

    typedef struct packed { logic last; logic [DW-1:0] data; } vec_t;
    typedef struct packed { int cyc; logic [W-1:0] data; } exp_t;

    // Reference model state
    vec_t mq[$];
    exp_t lane_q[CH][$];
    int   done_q[$];
    bit   exp_ready[int];
    bit   exp_busy[int];
    bit   exp_uf[int];
    bit   m_stream     = 1'b0;
    int   m_busy_until = -1;
    bit   m_uf         = 1'b0;

    int cyc    = 0;
    bit mon_en = 1'b0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, req);
        end
    endtask

    // One clock cycle. The inputs are applied, the model advances by the
    // specification's rules for that cycle, and then the clock edge passes.
    task automatic tick(input bit v, input bit l, input logic [DW-1:0] d,
                        input bit s, input bit r);
        bit   ready_now;
        bit   was_idle;
        vec_t vv;
        exp_t e;
        in_valid = v;
        in_last  = l;
        in_data  = d;
        start    = s;
        rst      = r;
        ready_now = !r && (mq.size() < D);
        was_idle  = !m_stream && (cyc > m_busy_until);
        exp_ready[cyc] = ready_now;
        exp_busy[cyc]  = !was_idle;
        exp_uf[cyc]    = m_uf;
        if (r) begin
            mq.delete();
            m_stream     = 1'b0;
            m_busy_until = -1;
            m_uf         = 1'b0;
            for (int i = 0; i < CH; i++) begin
                while (lane_q[i].size() > 0 && lane_q[i][$].cyc > cyc) begin
                    void'(lane_q[i].pop_back());
                end
            end
            while (done_q.size() > 0 && done_q[$] > cyc) begin
                void'(done_q.pop_back());
            end
        end else begin
            if (m_stream) begin
                if (mq.size() > 0) begin
                    vv = mq.pop_front();
                    for (int i = 0; i < CH; i++) begin
                        e.cyc  = cyc + 1 + i;
                        e.data = vv.data[i*W +: W];
                        lane_q[i].push_back(e);
                    end
                    if (vv.last) begin
                        m_stream     = 1'b0;
                        m_busy_until = cyc + CH - 1;
                        done_q.push_back(cyc + CH);
                    end
                end else begin
                    m_uf = 1'b1;
                end
            end
            if (v && ready_now) begin
                vv.last = l;
                vv.data = d;
                mq.push_back(vv);
            end
            if (s && was_idle) begin
                m_stream = 1'b1;
                m_uf     = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input bit l);
        tick(1'b1, l, d, 1'b0, 1'b0);
    endtask

    task automatic pulse_start();
        tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    function automatic logic [DW-1:0] mkvec(input int k);
        logic [DW-1:0] v;
        for (int i = 0; i < CH; i++) begin
            v[i*W +: W] = W'((k << 8) | i);
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] rvec();
        return {$urandom, $urandom};
    endfunction

    // Monitor / scoreboard
    exp_t          me;
    logic [W-1:0]  mw;
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_ready.exists(cyc)) chk("in_ready", 64'(in_ready), 64'(exp_ready[cyc]));
            if (exp_busy.exists(cyc))  chk("busy", 64'(busy), 64'(exp_busy[cyc]));
            if (exp_uf.exists(cyc))    chk("underflow_err", 64'(underflow_err), 64'(exp_uf[cyc]));
            for (int i = 0; i < CH; i++) begin
                mw = left_out_bus[i*W +: W];
                if (lane_valid[i]) begin
                    if (lane_q[i].size() == 0) begin
                        chk($sformatf("lane%0d_unexpected_valid", i), 64'(lane_valid[i]), 64'd0);
                    end else begin
                        me = lane_q[i].pop_front();
                        chk($sformatf("lane%0d_cycle", i), 64'(cyc), 64'(me.cyc));
                        chk($sformatf("lane%0d_data", i), 64'(mw), 64'(me.data));
                    end
                end else begin
                    chk($sformatf("lane%0d_bubble_zero", i), 64'(mw), 64'd0);
                    if (lane_q[i].size() > 0 && lane_q[i][0].cyc <= cyc) begin
                        me = lane_q[i].pop_front();
                        chk($sformatf("lane%0d_missing_valid", i), 64'(lane_valid[i]), 64'd1);
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 64'(done), 64'd0);
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                void'(done_q.pop_front());
                chk("done_missing", 64'(done), 64'd1);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        @(posedge clk);
        #1;
        cyc    = 1;
        mon_en = 1'b1;

        // Reset state, then release
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        nop(2);

        // Single frame of three vectors with recognisable lane words
        for (int k = 0; k < 3; k++) begin
            push(mkvec(k), k == 2);
        end
        nop(2);
        pulse_start();
        nop(10);

        // Backpressure: held in_valid overfills; stream while still pushing
        for (int k = 0; k < 10; k++) begin
            push(rvec(), k == 7);
        end
        tick(1'b1, 1'b0, rvec(), 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            push(rvec(), 1'b0);
        end
        push(rvec(), 1'b1);
        nop(12);
        pulse_start();
        nop(16);

        // Underflow: second (last) vector arrives three cycles after start
        push(rvec(), 1'b0);
        pulse_start();
        nop(2);
        push(rvec(), 1'b1);
        nop(10);

        // Back-to-back frames; second start the cycle after done
        push(rvec(), 1'b0);
        push(rvec(), 1'b1);
        push(rvec(), 1'b0);
        push(rvec(), 1'b1);
        pulse_start();
        nop(6);
        pulse_start();
        nop(10);

        // Start pulses during STREAM and during FLUSH are ignored
        push(rvec(), 1'b0);
        push(rvec(), 1'b0);
        push(rvec(), 1'b1);
        pulse_start();
        nop(1);
        pulse_start();
        nop(2);
        pulse_start();
        nop(10);

        // Reset in FLUSH with two entries still buffered
        push(rvec(), 1'b0);
        push(rvec(), 1'b1);
        push(rvec(), 1'b0);
        push(rvec(), 1'b1);
        pulse_start();
        nop(3);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        nop(8);

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rvec(),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
        end
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        nop(12);

        @(negedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("lane%0d_leftover", i), 64'(lane_q[i].size()), 64'd0);
        end
        chk("done_leftover", 64'(done_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
